// File: rtl/calc_seq_alu.sv
// calc_seq_alu: serial-input calculator. Operand A, an opcode beat and
// (for binary ops) operand B arrive one after another on data_in. The
// result is held on a registered output behind a valid/ready handshake.
// Chain mode feeds the previous result back in as the next operand A.
module calc_seq_alu #(
  parameter int W   = 8,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         err
);

  localparam int SHW = $clog2(W);

  typedef enum logic [1:0] {
    GET_A  = 2'd0,
    GET_OP = 2'd1,
    GET_B  = 2'd2,
    RES    = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_SQR = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8
  } opcode_t;

  state_t       state;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         chain_req;

  logic         beat;
  logic [3:0]   calc_op;
  logic [W-1:0] calc_b;
  logic [2*W-1:0] wide;
  logic [W-1:0] calc_res;
  logic         calc_ovf;
  logic         calc_err;
  logic         op_is_unary;

  assign in_ready = (state != RES);
  assign beat     = in_valid && in_ready;

  // Square and illegal opcodes need no B beat; they complete on the opcode beat.
  assign op_is_unary = (data_in[3:0] == OP_SQR) || (data_in[3:0] > OP_SHR);

  // Operation evaluated on the edge that completes it: on the opcode beat the
  // opcode comes straight from the bus, on the B beat the operand does.
  always_comb begin
    calc_op  = (state == GET_OP) ? data_in[3:0] : op;
    calc_b   = (state == GET_OP) ? a : data_in;
    wide     = '0;
    calc_ovf = 1'b0;
    calc_err = 1'b0;
    case (calc_op)
      OP_ADD: begin
        wide     = {{W{1'b0}}, a} + {{W{1'b0}}, calc_b};
        calc_ovf = |wide[2*W-1:W];
      end
      OP_SUB: begin
        wide     = {{W{1'b0}}, a} - {{W{1'b0}}, calc_b};
        calc_ovf = (a < calc_b);
      end
      OP_MUL: begin
        wide     = {{W{1'b0}}, a} * {{W{1'b0}}, calc_b};
        calc_ovf = |wide[2*W-1:W];
      end
      OP_SQR: begin
        wide     = {{W{1'b0}}, a} * {{W{1'b0}}, a};
        calc_ovf = |wide[2*W-1:W];
      end
      OP_AND:  wide = {{W{1'b0}}, a & calc_b};
      OP_OR:   wide = {{W{1'b0}}, a | calc_b};
      OP_XOR:  wide = {{W{1'b0}}, a ^ calc_b};
      OP_SHL:  wide = {{W{1'b0}}, a << calc_b[SHW-1:0]};
      OP_SHR:  wide = {{W{1'b0}}, a >> calc_b[SHW-1:0]};
      default: calc_err = 1'b1;
    endcase

    calc_res = wide[W-1:0];
    if (SAT && calc_ovf) begin
      calc_res = (calc_op == OP_SUB) ? '0 : '1;
    end
  end

  // Sequencer: collects beats, registers the result and runs the output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= GET_A;
      a         <= '0;
      b         <= '0;
      op        <= '0;
      chain_req <= 1'b0;
      result    <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values,
      // e.g. chaining reads the old result while the handshake retires it.
      case (state)
        GET_A: begin
          if (beat) begin
            a     <= data_in;
            state <= GET_OP;
          end
        end
        GET_OP: begin
          if (beat) begin
            op        <= data_in[3:0];
            chain_req <= data_in[4];
            if (op_is_unary) begin
              result    <= calc_res;
              ovf       <= calc_ovf;
              err       <= calc_err;
              out_valid <= 1'b1;
              state     <= RES;
            end else begin
              state <= GET_B;
            end
          end
        end
        GET_B: begin
          if (beat) begin
            b         <= data_in;
            result    <= calc_res;
            ovf       <= calc_ovf;
            err       <= calc_err;
            out_valid <= 1'b1;
            state     <= RES;
          end
        end
        RES: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (chain_req) begin
              a     <= result;
              state <= GET_OP;
            end else begin
              state <= GET_A;
            end
          end
        end
        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_seq_alu.sv
// Directed bench for calc_seq_alu: a wrapping (SAT=0) and a saturating
// (SAT=1) instance share one stimulus stream and are checked side by side.
module tb_calc_seq_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] data_in;
  logic       out_ready;

  logic       in_ready0, out_valid0, ovf0, err0;
  logic [7:0] result0;
  logic       in_ready1, out_valid1, ovf1, err1;
  logic [7:0] result1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  calc_seq_alu #(.W(8), .SAT(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .data_in(data_in), .out_valid(out_valid0), .out_ready(out_ready),
    .result(result0), .ovf(ovf0), .err(err0)
  );

  calc_seq_alu #(.W(8), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .data_in(data_in), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .ovf(ovf1), .err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Result check on both instances: wrap and saturate may differ in value/ovf.
  task automatic chk_res(input string tag, input logic [7:0] r0, input logic o0,
                         input logic [7:0] r1, input logic o1, input logic e);
    chk({tag, " valid0"}, out_valid0, 1'b1);
    chk({tag, " valid1"}, out_valid1, 1'b1);
    chk({tag, " res0"}, result0, r0);
    chk({tag, " ovf0"}, ovf0, o0);
    chk({tag, " res1"}, result1, r1);
    chk({tag, " ovf1"}, ovf1, o1);
    chk({tag, " err0"}, err0, e);
    chk({tag, " err1"}, err1, e);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    chk("in_ready before beat", {in_ready1, in_ready0}, 2'b11);
    in_valid = 1'b1;
    data_in  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic take;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("valid drops after handshake", {out_valid1, out_valid0}, 2'b00);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset result", {result1, result0}, 16'h0000);
    chk("reset flags", {out_valid1, ovf1, err1, out_valid0, ovf0, err0}, 6'b0);
    chk("reset in_ready", {in_ready1, in_ready0}, 2'b11);

    // add with carry: 200+100
    send(8'd200);
    send(8'h00);
    chk("add no result before B", {out_valid1, out_valid0}, 2'b00);
    send(8'd100);
    chk_res("add 200+100", 8'd44, 1'b1, 8'd255, 1'b1, 1'b0);
    chk("in_ready low in RES", {in_ready1, in_ready0}, 2'b00);
    take();

    // sub with borrow: 5-9
    send(8'd5); send(8'h01); send(8'd9);
    chk_res("sub 5-9", 8'd252, 1'b1, 8'd0, 1'b1, 1'b0);
    take();

    // mul overflow: 20*13 = 260
    send(8'd20); send(8'h02); send(8'd13);
    chk_res("mul 20*13", 8'd4, 1'b1, 8'd255, 1'b1, 1'b0);
    take();

    // square skips B: 16*16 = 256
    send(8'd16); send(8'h03);
    chk_res("square 16", 8'd0, 1'b1, 8'd255, 1'b1, 1'b0);
    take();
    send(8'd15); send(8'h03);
    chk_res("square 15", 8'd225, 1'b0, 8'd225, 1'b0, 1'b0);
    take();

    // chain: (7+3)*5 >> 1
    send(8'd7); send(8'h10); send(8'd3);
    chk_res("chain add", 8'd10, 1'b0, 8'd10, 1'b0, 1'b0);
    take();
    send(8'h12); send(8'd5);
    chk_res("chain mul", 8'd50, 1'b0, 8'd50, 1'b0, 1'b0);
    take();
    send(8'h08); send(8'd1);
    chk_res("chain shr", 8'd25, 1'b0, 8'd25, 1'b0, 1'b0);
    take();

    // illegal opcode: err set, B skipped; next legal op clears it
    send(8'd9); send(8'h0F);
    chk_res("illegal op", 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    take();
    send(8'd3); send(8'h04); send(8'd6);
    chk_res("and clears err", 8'd2, 1'b0, 8'd2, 1'b0, 1'b0);
    take();

    // illegal with chain: next A is 0
    send(8'd9); send(8'h1F);
    chk_res("illegal chain", 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    take();
    send(8'h00); send(8'd4);
    chk_res("add after illegal chain", 8'd4, 1'b0, 8'd4, 1'b0, 1'b0);
    take();

    // shifts use only the low log2(W) bits of B; xor
    send(8'h81); send(8'h07); send(8'd9);
    chk_res("shl by 9 mod 8", 8'h02, 1'b0, 8'h02, 1'b0, 1'b0);
    take();
    send(8'h80); send(8'h08); send(8'd7);
    chk_res("shr by 7", 8'h01, 1'b0, 8'h01, 1'b0, 1'b0);
    take();
    send(8'hF0); send(8'h06); send(8'h3C);
    chk_res("xor", 8'hCC, 1'b0, 8'hCC, 1'b0, 1'b0);
    take();

    // backpressure: result held, beats ignored while in RES
    send(8'd10); send(8'h05); send(8'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = 8'd77;
      chk("stall in_ready", {in_ready1, in_ready0}, 2'b00);
      chk_res("stall hold", 8'd11, 1'b0, 8'd11, 1'b0, 1'b0);
      @(posedge clk);
    end
    // handshake with in_valid high: beat taken only on the following edge
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release valid", {out_valid1, out_valid0}, 2'b00);
    chk("release in_ready", {in_ready1, in_ready0}, 2'b11);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    send(8'h00); send(8'd1);
    chk_res("beat after release", 8'd78, 1'b0, 8'd78, 1'b0, 1'b0);
    take();

    // reset while waiting for B, then a clean 1+1
    send(8'd50); send(8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid reset result", {result1, result0}, 16'h0000);
    chk("mid reset flags", {out_valid1, ovf1, err1, out_valid0, ovf0, err0}, 6'b0);
    send(8'd1); send(8'h00);
    chk("post reset no early valid", {out_valid1, out_valid0}, 2'b00);
    send(8'd1);
    chk_res("post reset 1+1", 8'd2, 1'b0, 8'd2, 1'b0, 1'b0);
    take();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_seq_alu.md
Name: calc_seq_alu

Overview:
- Parametrised serial-input calculator. Operands and opcode arrive as beats on one `data_in` bus: A, then OP, then B (when the opcode needs it).
- Result is returned on a registered output with a valid/ready handshake, plus overflow and error flags.
- Adds a chain mode: the previous result becomes operand A of the next operation.
- Sits between the command front-end and the result sink in the datapath.

Parameters:
- W, 8: operand and result width in bits. Legal range 8..32.
- SAT, 0: 1 = add/sub/mul/square saturate; 0 = wrap modulo 2^W.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  data_in beat is valid.
- in_ready  out  1  block accepts a beat; low only in state RES.
- data_in  in  W  operand beat, or opcode beat using bits [4:0].
- out_valid  out  1  result available.
- out_ready  in  1  sink accepts the result.
- result  out  W  operation result.
- ovf  out  1  true result did not fit in W bits (add/sub/mul/square only).
- err  out  1  illegal opcode was issued.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - Reset values: state=GET_A, result=0, out_valid=0, ovf=0, err=0, chain=0. Internal A/B/op registers cleared.
  - Reset mid-sequence discards all partial operands and any pending result.
- Beat acceptance:
  - A beat is accepted when in_valid && in_ready.
  - in_ready = (state != RES).
- States: GET_A, GET_OP, GET_B, RES.
  - GET_A: accept beat -> A=data_in; go to GET_OP.
  - GET_OP: accept beat -> op=data_in[3:0], chain_req=data_in[4].
    - Opcodes 3 (square) and illegal opcodes (>8) skip GET_B and go straight to RES, result computed on this edge.
    - All other opcodes go to GET_B.
  - GET_B: accept beat -> compute the result on this edge; go to RES.
  - RES: out_valid=1; result, ovf, err held stable until out_ready.
    - On out_valid && out_ready: out_valid drops on the next edge.
    - Next state is GET_OP with A=result if chain_req=1; otherwise GET_A.
- Latency: result and out_valid are registered. out_valid rises on the edge after the final operand beat, i.e. visible the next cycle.
- Opcodes:
  - 0 add: A+B.
  - 1 sub: A-B.
  - 2 mul: low W bits of A*B.
  - 3 square: A*A.
  - 4 and, 5 or, 6 xor.
  - 7 shl: A << B[log2(W)-1:0].
  - 8 shr: logical A >> B[log2(W)-1:0].
  - 9..15: illegal -> err=1, result=0, ovf=0.
- Arithmetic: all unsigned. Compute at 2W internally.
  - ovf=1 when: add carry out; sub borrow (A<B); mul/square with upper W bits nonzero.
  - SAT=1 and ovf=1: add/mul/square -> 2^W-1; sub -> 0.
  - Logic and shift ops: ovf=0, SAT has no effect.
- err and ovf refer only to the current result. Both are cleared when the next result is produced.
- in_valid while in RES is ignored: no beat is consumed.
- Simultaneous out handshake and new in_valid in RES: the beat is not accepted that cycle (in_ready=0). It is accepted one cycle later in GET_A/GET_OP.
- Chain after an illegal opcode: the chain bit is still honoured, so A=0.

Test Plan:
- W=8, SAT=0: beats 200, op 0, 100 -> result=44, ovf=1, out_valid rises 1 cycle after the B beat.
- W=8, SAT=1: 200 + 100 -> 255, ovf=1. Sub 5-9 -> 0, ovf=1. Mul 20*13 -> 255, ovf=1. With SAT=0: sub -> 252, mul -> 4.
- Square: beats 16, op 3 -> no B beat consumed; result=0, ovf=1 (SAT=0) or 255 (SAT=1). Beats 15, op 3 -> 225, ovf=0.
- Chain: 7, op 0x10 (add+chain), 3 -> 10. Then op 2, 5 with no A beat -> 50. Then op 8, 1 -> 25.
- Illegal op 0x0F after A=9 -> err=1, result=0, GET_B skipped. The next legal op clears err.
- Backpressure: hold out_ready=0 for 5 cycles -> result stable, in_ready=0, in_valid beats ignored. Assert rst during GET_B -> all outputs 0; the following sequence 1+1 -> 2.
